// File: rtl/heap_array_allocator_pkg.sv
// heap_alloc_pkg
//   Shared types and defaults for the heap array allocator.
//   - state_e     : controller states (IDLE, CLEAR, RESP)
//   - *_DEFAULT   : default sizing constants shared with the rest of the datapath
//   - idx_w()     : index width helper, never less than one bit
//   - RSP_REQ_W   : requester index width for the default requester count
package heap_alloc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int unsigned MEW_DEFAULT     = 12;
  localparam int unsigned NAREA_DEFAULT   = 3;
  localparam int unsigned NARRAYS_DEFAULT = 4;
  localparam int unsigned NREQ_DEFAULT    = 2;

  // Width needed to index n items; a single item still gets one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned RSP_REQ_W = idx_w(NREQ_DEFAULT);

endpackage

// File: rtl/heap_array_allocator_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts one past the last
//   winner and wraps, so every requester is served within NReq grants.
//   Ports:
//     valid_i  : pending request per requester
//     last_i   : index of the previous winner
//     enable_i : grants are only produced when high
//     grant_o  : one-hot grant
//     index_o  : index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int unsigned NReq = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NReq-1:0] valid_i,
  input  logic [IW-1:0]   last_i,
  input  logic            enable_i,
  output logic [NReq-1:0] grant_o,
  output logic [IW-1:0]   index_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant_o = '0;
    index_o = '0;
    found   = 1'b0;
    cand    = '0;
    if (enable_i) begin
      for (int off = 1; off <= int'(NReq); off++) begin
        cand = IW'((int'(last_i) + off) % int'(NReq));
        if (!found && valid_i[cand]) begin
          found         = 1'b1;
          grant_o[cand] = 1'b1;
          index_o       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/heap_array_allocator.sv
// heap_array_allocator
//   Allocates and frees fixed-size heap arrays for several requesters.
//   Freed ids are recycled LIFO; fresh ids come from a high-water counter.
//   A bitmap of freed ids catches double frees. Each successful alloc
//   zeroes the array's NArea heap slots and its size entry before replying.
//   Ports:
//     clock, reset            : rising-edge clock, async active-low reset
//     req_valid/free/array    : per-requester request (free=1) and id to free
//     req_ready               : one-hot grant, combinational in the grant cycle
//     rsp_valid/req/array/error : one-cycle response
//     heap_we/addr/wdata      : heap clear write port (data always 0)
//     size_we/addr/wdata      : arraySizes clear write port (data always 0)
//     busy                    : controller not idle
//     allocs                  : high-water count of ids handed out
module heap_array_allocator
  import heap_alloc_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = MEW_DEFAULT,
  parameter int unsigned NArea              = NAREA_DEFAULT,
  parameter int unsigned NArrays            = NARRAYS_DEFAULT,
  parameter int unsigned NReq               = NREQ_DEFAULT
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NReq-1:0]                    req_valid,
  input  logic [NReq-1:0]                    req_free,
  input  logic [NReq*MemoryElementWidth-1:0] req_array,
  output logic [NReq-1:0]                    req_ready,
  output logic                               rsp_valid,
  output logic [idx_w(NReq)-1:0]             rsp_req,
  output logic [MemoryElementWidth-1:0]      rsp_array,
  output logic                               rsp_error,
  output logic                               heap_we,
  output logic [MemoryElementWidth-1:0]      heap_addr,
  output logic [MemoryElementWidth-1:0]      heap_wdata,
  output logic                               size_we,
  output logic [MemoryElementWidth-1:0]      size_addr,
  output logic [MemoryElementWidth-1:0]      size_wdata,
  output logic                               busy,
  output logic [MemoryElementWidth-1:0]      allocs
);

  localparam int unsigned MW = MemoryElementWidth;
  localparam int unsigned RW = idx_w(NReq);
  localparam int unsigned AW = idx_w(NArrays);
  localparam int unsigned SW = idx_w(NArrays + 1);  // stack depth 0..NArrays
  localparam int unsigned KW = idx_w(NArea);

  state_e          state_q, state_d;
  logic [SW-1:0]   top_q, top_d;
  logic [NArrays-1:0] bitmap_q, bitmap_d;
  logic [MW-1:0]   allocs_q, allocs_d;
  logic [RW-1:0]   last_q, last_d;
  logic [MW-1:0]   id_q, id_d;
  logic [RW-1:0]   req_q, req_d;
  logic            err_q, err_d;
  logic [KW-1:0]   k_q, k_d;

  logic [MW-1:0]   stack_q [NArrays];
  logic            push_we;

  logic [MW-1:0]   req_array_a [NReq];
  logic [NReq-1:0] grant;
  logic [RW-1:0]   grant_idx;
  logic [MW-1:0]   free_id;
  logic            free_bad;
  logic [AW-1:0]   pop_idx;

  for (genvar gi = 0; gi < int'(NReq); gi++) begin : g_unpack
    assign req_array_a[gi] = req_array[gi*MW +: MW];
  end

  // Gating with reset keeps every output at 0 while reset is held.
  rr_arbiter #(.NReq(NReq), .IW(RW)) u_arb (
    .valid_i  (req_valid),
    .last_i   (last_q),
    .enable_i ((state_q == IDLE) && reset),
    .grant_o  (grant),
    .index_o  (grant_idx)
  );

  assign req_ready = grant;
  assign free_id   = req_array_a[grant_idx];
  assign pop_idx   = AW'(top_q - SW'(1));
  // Bitmap lookup only matters for ids below allocs, which are in range.
  assign free_bad  = (free_id >= allocs_q) || bitmap_q[AW'(free_id)];

  always_comb begin
    state_d  = state_q;
    top_d    = top_q;
    bitmap_d = bitmap_q;
    allocs_d = allocs_q;
    last_d   = last_q;
    id_d     = id_q;
    req_d    = req_q;
    err_d    = err_q;
    k_d      = k_q;
    push_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          last_d = grant_idx;
          req_d  = grant_idx;
          k_d    = '0;
          if (!req_free[grant_idx]) begin
            if (top_q != '0) begin
              // Reuse the most recently freed id first.
              id_d              = stack_q[pop_idx];
              top_d             = top_q - SW'(1);
              bitmap_d[AW'(stack_q[pop_idx])] = 1'b0;
              err_d             = 1'b0;
              state_d           = CLEAR;
            end else if (allocs_q < MW'(NArrays)) begin
              id_d     = allocs_q;
              allocs_d = allocs_q + MW'(1);
              err_d    = 1'b0;
              state_d  = CLEAR;
            end else begin
              id_d    = '0;
              err_d   = 1'b1;
              state_d = RESP;
            end
          end else begin
            if (free_bad) begin
              id_d  = '0;
              err_d = 1'b1;
            end else begin
              id_d                   = free_id;
              err_d                  = 1'b0;
              push_we                = 1'b1;
              top_d                  = top_q + SW'(1);
              bitmap_d[AW'(free_id)] = 1'b1;
            end
            state_d = RESP;
          end
        end
      end
      CLEAR: begin
        if (k_q == KW'(NArea - 1)) state_d = RESP;
        else                       k_d     = k_q + KW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      top_q    <= '0;
      bitmap_q <= '0;
      allocs_q <= '0;
      last_q   <= RW'(NReq - 1);
      id_q     <= '0;
      req_q    <= '0;
      err_q    <= 1'b0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      top_q    <= top_d;
      bitmap_q <= bitmap_d;
      allocs_q <= allocs_d;
      last_q   <= last_d;
      id_q     <= id_d;
      req_q    <= req_d;
      err_q    <= err_d;
      k_q      <= k_d;
    end
  end

  // Stack contents need no reset: only entries below top are ever read.
  always_ff @(posedge clock) begin
    if (push_we) stack_q[AW'(top_q)] <= free_id;
  end

  assign busy       = (state_q != IDLE);
  assign heap_we    = (state_q == CLEAR);
  assign heap_addr  = heap_we ? (id_q * MW'(NArea) + MW'(k_q)) : '0;
  assign heap_wdata = '0;
  assign size_we    = (state_q == CLEAR) && (k_q == '0);
  assign size_addr  = size_we ? id_q : '0;
  assign size_wdata = '0;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_req    = rsp_valid ? req_q : '0;
  assign rsp_array  = rsp_valid ? id_q : '0;
  assign rsp_error  = rsp_valid && err_q;
  assign allocs     = allocs_q;

endmodule

// File: tb/tb_heap_array_allocator.sv
module tb_heap_array_allocator;

  localparam int MW  = 12;
  localparam int NA  = 3;
  localparam int NAR = 4;
  localparam int NR  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_free  = '0;
  logic [NR*MW-1:0]  req_array = '0;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic [0:0]        rsp_req;
  logic [MW-1:0]     rsp_array;
  logic              rsp_error;
  logic              heap_we;
  logic [MW-1:0]     heap_addr;
  logic [MW-1:0]     heap_wdata;
  logic              size_we;
  logic [MW-1:0]     size_addr;
  logic [MW-1:0]     size_wdata;
  logic              busy;
  logic [MW-1:0]     allocs;

  heap_array_allocator #(
    .MemoryElementWidth(MW), .NArea(NA), .NArrays(NAR), .NReq(NR)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_free(req_free), .req_array(req_array),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_req(rsp_req), .rsp_array(rsp_array), .rsp_error(rsp_error),
    .heap_we(heap_we), .heap_addr(heap_addr), .heap_wdata(heap_wdata),
    .size_we(size_we), .size_addr(size_addr), .size_wdata(size_wdata),
    .busy(busy), .allocs(allocs)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: freed ids as a LIFO queue (membership = "already freed"),
  // high-water count, and the last round-robin winner.
  int m_allocs;
  int m_stack[$];
  int m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit in_stack(input int id);
    foreach (m_stack[i]) if (m_stack[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_allocs = 0;
    m_stack.delete();
    m_last = NR - 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_rsp"}, {29'd0, rsp_valid, rsp_error, heap_we}, 0);
    check({tag, "_size_we"}, 32'(size_we), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_allocs"}, 32'(allocs), 0);
    check({tag, "_addrs"}, {8'd0, heap_addr, size_addr}, 0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // Serve every requester in mask; fr bit = free, arr holds the ids to free.
  task automatic serve(input int mask, input int fr, input logic [NR*MW-1:0] arr);
    int pending;
    pending   = mask;
    req_free  = NR'(fr);
    req_array = arr;
    while (pending != 0) begin
      int w;
      int is_free;
      int id;
      int exp_id;
      int exp_err;
      int clr;
      int lat;
      @(posedge clock);
      #1 req_valid = NR'(pending);
      #1;
      w = -1;
      for (int o = 1; o <= NR; o++) begin
        int c;
        c = (m_last + o) % NR;
        if (w < 0 && ((pending >> c) & 1) == 1) w = c;
      end
      check("grant", 32'(req_ready), 1 << w);
      m_last  = w;
      is_free = (fr >> w) & 1;
      id      = int'(MW'(arr >> (w * MW)));
      clr = 0; exp_err = 0; exp_id = 0;
      if (is_free == 0) begin
        if (m_stack.size() > 0) begin
          exp_id = m_stack.pop_back();
          clr = 1;
        end else if (m_allocs < NAR) begin
          exp_id = m_allocs;
          m_allocs++;
          clr = 1;
        end else begin
          exp_err = 1;
        end
      end else begin
        if (id >= m_allocs || in_stack(id)) exp_err = 1;
        else begin
          m_stack.push_back(id);
          exp_id = id;
        end
      end
      pending = pending & ~(1 << w);
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        @(posedge clock);
        #1;
        if (c == 1) req_valid = NR'(pending);
        #1;
        check("busy", 32'(busy), 1);
        check("ready_while_busy", 32'(req_ready), 0);
        if (rsp_valid) lat = c;
        else begin
          check("heap_we", 32'(heap_we), (clr == 1 && c <= NA) ? 1 : 0);
          if (heap_we) begin
            check("heap_addr", 32'(heap_addr), exp_id * NA + c - 1);
            check("heap_wdata", 32'(heap_wdata), 0);
          end
          check("size_we", 32'(size_we), (clr == 1 && c == 1) ? 1 : 0);
          if (size_we) begin
            check("size_addr", 32'(size_addr), exp_id);
            check("size_wdata", 32'(size_wdata), 0);
          end
        end
      end
      check("latency", lat, (clr == 1) ? NA + 1 : 1);
      if (lat != 0) begin
        check("rsp_req", 32'(rsp_req), w);
        check("rsp_array", 32'(rsp_array), exp_err ? 0 : exp_id);
        check("rsp_error", 32'(rsp_error), exp_err);
        check("rsp_heap_we", 32'(heap_we), 0);
      end
      check("allocs", 32'(allocs), m_allocs);
      $display("txn req=%0d op=%s arg=%0d -> id=%0d err=%0d lat=%0d allocs=%0d",
               w, is_free ? "free" : "alloc", id, rsp_array, rsp_error, lat, allocs);
    end
  endtask

  function automatic logic [NR*MW-1:0] ids(input int id1, input int id0);
    return {MW'(id1), MW'(id0)};
  endfunction

  initial begin
    // Reset state with requests pending: nothing may be granted.
    req_valid = 2'b11;
    #2;
    check_all_zero("reset_state");
    do_reset();

    // 1: single alloc on requester 0
    serve(1, 0, ids(0, 0));
    check("t1_allocs", 32'(allocs), 1);

    // 2: simultaneous allocs, twice; requester 0 wins each pair
    do_reset();
    serve(3, 0, ids(0, 0));
    serve(3, 0, ids(0, 0));
    check("t2_allocs", 32'(allocs), 4);

    // 3: alloc 0,1, free 1, alloc gets 1 back
    do_reset();
    serve(1, 0, ids(0, 0));
    serve(1, 0, ids(0, 0));
    serve(2, 2, ids(1, 0));
    serve(1, 0, ids(0, 0));
    check("t3_allocs", 32'(allocs), 2);

    // 4: double free of id 0
    do_reset();
    serve(1, 0, ids(0, 0));
    serve(1, 1, ids(0, 0));
    serve(2, 2, ids(0, 0));
    serve(1, 0, ids(0, 0));
    serve(1, 0, ids(0, 0));

    // 5: exhaustion and out-of-range free
    do_reset();
    for (int i = 0; i < 5; i++) serve(1, 0, ids(0, 0));
    check("t5_allocs", 32'(allocs), NAR);
    serve(2, 2, ids(7, 0));

    // 6: reset in the middle of a clear
    do_reset();
    @(posedge clock);
    #1 req_valid = 2'b01; req_free = 2'b00;
    #1 check("t6_grant", 32'(req_ready), 1);
    @(posedge clock);
    #1 req_valid = 2'b00;
    #1 check("t6_k0_we", 32'(heap_we), 1);
    @(posedge clock);
    #2 check("t6_k1_addr", 32'(heap_addr), 1);
    reset = 1'b0;
    #1;
    check("t6_heap_we", 32'(heap_we), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_allocs", 32'(allocs), 0);
    check("t6_rsp", 32'(rsp_valid), 0);
    repeat (2) begin
      @(posedge clock);
      #2 check("t6_rsp_in_reset", 32'(rsp_valid), 0);
    end
    #1 reset = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clock);
      #2 check("t6_rsp_after", {30'd0, rsp_valid, heap_we}, 0);
    end
    serve(1, 0, ids(0, 0));

    // Random mix of allocs and frees from both requesters.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int mask;
      int fr;
      mask = int'($urandom_range(1, 3));
      fr   = (($urandom_range(0, 9) < 4) ? 1 : 0) | (($urandom_range(0, 9) < 4) ? 2 : 0);
      serve(mask, fr, ids(int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
